// File: rtl/control_escritura_rtc_if.sv
// Signal bundle between the RTC write sequencer, the local-memory distribution mux and the RTC bus pins.
interface control_escritura_rtc_if;
  logic       in_iniciar;
  logic [1:0] in_sel_grupo;
  logic [7:0] in_dato_para_rtc;
  logic       out_reg_wr;
  logic [3:0] out_addr_mem_local;
  logic [7:0] out_ad_bus;
  logic       out_ad_oe;
  logic       out_cs_n;
  logic       out_wr_n;
  logic       out_rd_n;
  logic       out_a_d_n;
  logic       out_ocupado;
  logic       out_fin;
  logic [3:0] dbg_estado;

  // Handshake: in_iniciar is the request (valid); the sequencer is ready only in IDLE.
  // A request seen while not ready is dropped, never queued; out_fin closes an accepted request.
  modport master (
    output in_iniciar, in_sel_grupo, in_dato_para_rtc,
    input  out_reg_wr, out_addr_mem_local, out_ad_bus, out_ad_oe, out_cs_n, out_wr_n,
    input  out_rd_n, out_a_d_n, out_ocupado, out_fin, dbg_estado
  );

  modport slave (
    input  in_iniciar, in_sel_grupo, in_dato_para_rtc,
    output out_reg_wr, out_addr_mem_local, out_ad_bus, out_ad_oe, out_cs_n, out_wr_n,
    output out_rd_n, out_a_d_n, out_ocupado, out_fin, dbg_estado
  );
endinterface

// File: rtl/control_escritura_rtc.sv
// Write sequencer for the multiplexed RTC bus: one address phase plus one data phase per local register.
// Optional TRANSFER_CMD_EN appends the RTC transfer command write (0xF0, 0xF0) after each group.
module control_escritura_rtc #(
  parameter int T_FASE = 4
) (
  input logic                    clk,
  input logic                    reset,
  control_escritura_rtc_if.slave rtc
);
  typedef enum logic [3:0] {
    IDLE, CARGA, DIR_SETUP, DIR_WR, DIR_HOLD, DAT_SETUP, DAT_WR, DAT_HOLD, SIGUIENTE, FIN
  } estado_t;

  localparam logic [3:0] CNT_MAX = 4'(T_FASE - 1);

  estado_t    estado, estado_sig;
  logic [3:0] cnt, cnt_sig, idx, idx_sig, ult, ult_sig;
  logic       es_cmd, es_cmd_sig;
  logic       fase_fin, en_fase;

  logic       reg_wr_q, reg_wr_d, oe_q, oe_d, cs_n_q, cs_n_d, wr_n_q, wr_n_d;
  logic       a_d_n_q, a_d_n_d, ocupado_q, ocupado_d, fin_q, fin_d;
  logic [3:0] addr_q, addr_d;
  logic [7:0] ad_bus_q, ad_bus_d;

  function automatic logic [7:0] dir_rtc(input logic [3:0] i);
    case (i)
      4'd0: dir_rtc = 8'h21;
      4'd1: dir_rtc = 8'h22;
      4'd2: dir_rtc = 8'h23;
      4'd3: dir_rtc = 8'h24;
      4'd4: dir_rtc = 8'h25;
      4'd5: dir_rtc = 8'h26;
      4'd6: dir_rtc = 8'h27;
      4'd7: dir_rtc = 8'h41;
      4'd8: dir_rtc = 8'h42;
      4'd9: dir_rtc = 8'h43;
      default: dir_rtc = 8'h00;
    endcase
  endfunction

  function automatic logic [3:0] primero(input logic [1:0] sel);
    case (sel)
      2'b01:   primero = 4'd3;
      2'b10:   primero = 4'd7;
      default: primero = 4'd0;
    endcase
  endfunction

  function automatic logic [3:0] ultimo(input logic [1:0] sel);
    case (sel)
      2'b00:   ultimo = 4'd2;
      2'b01:   ultimo = 4'd6;
      default: ultimo = 4'd9;
    endcase
  endfunction

  assign fase_fin = (cnt == 4'd0);
  assign en_fase  = estado inside {DIR_SETUP, DIR_WR, DIR_HOLD, DAT_SETUP, DAT_WR, DAT_HOLD};

  // Outputs are decoded from the current state and registered, so every pin lags the state by one cycle.
  always_comb begin
    estado_sig = estado;
    cnt_sig    = cnt;
    idx_sig    = idx;
    ult_sig    = ult;
    es_cmd_sig = es_cmd;
    reg_wr_d   = es_cmd;
    addr_d     = addr_q;
    ad_bus_d   = ad_bus_q;
    oe_d       = 1'b0;
    cs_n_d     = 1'b1;
    wr_n_d     = 1'b1;
    a_d_n_d    = 1'b1;
    ocupado_d  = 1'b1;
    fin_d      = 1'b0;
    if (en_fase) begin
      cnt_sig = fase_fin ? CNT_MAX : cnt - 4'd1;
      oe_d    = 1'b1;
      cs_n_d  = 1'b0;
    end
    case (estado)
      IDLE: begin
        reg_wr_d  = 1'b1;
        ocupado_d = 1'b0;
        if (rtc.in_iniciar) begin
          estado_sig = CARGA;
          idx_sig    = primero(rtc.in_sel_grupo);
          ult_sig    = ultimo(rtc.in_sel_grupo);
          es_cmd_sig = 1'b0;
        end
      end
      CARGA: begin
        addr_d     = idx;
        cnt_sig    = CNT_MAX;
        estado_sig = DIR_SETUP;
      end
      DIR_SETUP: begin
        a_d_n_d  = 1'b0;
        ad_bus_d = es_cmd ? 8'hF0 : dir_rtc(idx);
        if (fase_fin) estado_sig = DIR_WR;
      end
      DIR_WR: begin
        a_d_n_d = 1'b0;
        wr_n_d  = 1'b0;
        if (fase_fin) estado_sig = DIR_HOLD;
      end
      DIR_HOLD: begin
        a_d_n_d = 1'b0;
        if (fase_fin) estado_sig = DAT_SETUP;
      end
      DAT_SETUP: begin
        // The mux byte is captured once, on the first cycle of the phase, and held.
        if (cnt == CNT_MAX) ad_bus_d = es_cmd ? 8'hF0 : rtc.in_dato_para_rtc;
        if (fase_fin) estado_sig = DAT_WR;
      end
      DAT_WR: begin
        wr_n_d = 1'b0;
        if (fase_fin) estado_sig = DAT_HOLD;
      end
      DAT_HOLD: begin
        if (fase_fin) estado_sig = SIGUIENTE;
      end
      SIGUIENTE: begin
        if (es_cmd || idx == ult || idx == 4'd9) begin
`ifdef TRANSFER_CMD_EN
          if (!es_cmd) begin
            es_cmd_sig = 1'b1;
            estado_sig = CARGA;
          end else begin
            estado_sig = FIN;
          end
`else
          estado_sig = FIN;
`endif
        end else begin
          idx_sig    = idx + 4'd1;
          estado_sig = CARGA;
        end
      end
      FIN: begin
        reg_wr_d   = 1'b1;
        ocupado_d  = 1'b0;
        fin_d      = 1'b1;
        estado_sig = IDLE;
      end
      default: begin
        reg_wr_d   = 1'b1;
        ocupado_d  = 1'b0;
        estado_sig = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado    <= IDLE;
      cnt       <= 4'd0;
      idx       <= 4'd0;
      ult       <= 4'd0;
      es_cmd    <= 1'b0;
      reg_wr_q  <= 1'b1;
      addr_q    <= 4'd0;
      ad_bus_q  <= 8'h00;
      oe_q      <= 1'b0;
      cs_n_q    <= 1'b1;
      wr_n_q    <= 1'b1;
      a_d_n_q   <= 1'b1;
      ocupado_q <= 1'b0;
      fin_q     <= 1'b0;
    end else begin
      estado    <= estado_sig;
      cnt       <= cnt_sig;
      idx       <= idx_sig;
      ult       <= ult_sig;
      es_cmd    <= es_cmd_sig;
      reg_wr_q  <= reg_wr_d;
      addr_q    <= addr_d;
      ad_bus_q  <= ad_bus_d;
      oe_q      <= oe_d;
      cs_n_q    <= cs_n_d;
      wr_n_q    <= wr_n_d;
      a_d_n_q   <= a_d_n_d;
      ocupado_q <= ocupado_d;
      fin_q     <= fin_d;
    end
  end

  assign rtc.out_reg_wr         = reg_wr_q;
  assign rtc.out_addr_mem_local = addr_q;
  assign rtc.out_ad_bus         = ad_bus_q;
  assign rtc.out_ad_oe          = oe_q;
  assign rtc.out_cs_n           = cs_n_q;
  assign rtc.out_wr_n           = wr_n_q;
  assign rtc.out_rd_n           = 1'b1;
  assign rtc.out_a_d_n          = a_d_n_q;
  assign rtc.out_ocupado        = ocupado_q;
  assign rtc.out_fin            = fin_q;
  assign rtc.dbg_estado         = estado;
endmodule

// File: tb/tb_control_escritura_rtc.sv
// Directed bench for control_escritura_rtc: write-pair scoreboard, bus protocol monitor, timing checks.
module tb_control_escritura_rtc;
`ifdef TRANSFER_CMD_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  bit   rst_q = 1'b1;
  control_escritura_rtc_if rtc_if ();

  control_escritura_rtc #(.T_FASE(4)) dut (.clk(clk), .reset(reset), .rtc(rtc_if));

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) rst_q <= reset;

  // ---------------- mux model and tables ----------------
  logic [7:0] mux_tab [10];
  logic [7:0] tab_dir [10] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h41, 8'h42, 8'h43};
  assign rtc_if.in_dato_para_rtc = (rtc_if.out_addr_mem_local < 4'd10) ? mux_tab[rtc_if.out_addr_mem_local] : 8'hEE;

  // ---------------- scoreboard state ----------------
  logic [8:0] exp_q[$];
  logic [8:0] obs_mem [128];
  int obs_n = 0;
  int rd_ptr = 0;
  int viol = 0;
  int n_checks = 0;
  int n_errors = 0;

  // Bus monitor: records every wr_n falling edge as {a_d_n, ad_bus} and counts protocol violations.
  int   lo_cnt = 0, stable = 100, since_rise = 100;
  logic wr_prev = 1'b1, adn_prev = 1'b1;
  logic [7:0] bus_prev = 8'h00;
  always @(negedge clk) begin
    logic chg;
    if (rst_q) begin
      lo_cnt = 0; stable = 100; since_rise = 100;
      wr_prev = rtc_if.out_wr_n; adn_prev = rtc_if.out_a_d_n; bus_prev = rtc_if.out_ad_bus;
    end else begin
      chg = (rtc_if.out_ad_bus !== bus_prev) || (rtc_if.out_a_d_n !== adn_prev);
      stable = chg ? 1 : ((stable < 100) ? stable + 1 : stable);
      if (rtc_if.out_wr_n === 1'b1 && wr_prev === 1'b0) begin
        if (lo_cnt != 4) begin viol++; $display("protocol: wr_n low window %0d cycles", lo_cnt); end
        lo_cnt = 0; since_rise = 1;
      end else if (since_rise < 100) begin
        since_rise++;
      end
      if (chg && since_rise < 5) begin viol++; $display("protocol: bus changed %0d cycles after wr_n rise", since_rise); end
      if (rtc_if.out_wr_n === 1'b0) begin
        lo_cnt++;
        if (rtc_if.out_cs_n !== 1'b0) begin viol++; $display("protocol: wr_n low with cs_n high"); end
        if (wr_prev === 1'b1) begin
          if (stable < 5) begin viol++; $display("protocol: bus stable only %0d cycles at wr_n fall", stable - 1); end
          if (obs_n < 128) obs_mem[obs_n] = {rtc_if.out_a_d_n, rtc_if.out_ad_bus};
          obs_n++;
        end
      end
      if (rtc_if.out_rd_n !== 1'b1) begin viol++; $display("protocol: rd_n asserted"); end
      wr_prev = rtc_if.out_wr_n; adn_prev = rtc_if.out_a_d_n; bus_prev = rtc_if.out_ad_bus;
    end
  end

  // ---------------- driver / check tasks ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic iniciar(input logic [1:0] sel);
    @(posedge clk); #1;
    rtc_if.in_sel_grupo = sel;
    rtc_if.in_iniciar   = 1'b1;
    @(posedge clk); #1;
    rtc_if.in_iniciar   = 1'b0;
  endtask

  // Counts edges until out_fin, checking ocupado on the way and counting cycles with reg_wr low.
  task automatic esperar_fin(input int limite, output int ciclos, output bit ocup_ok, output int n_rw0);
    ciclos = 0; ocup_ok = 1'b1; n_rw0 = 0;
    do begin
      @(posedge clk); #1;
      ciclos++;
      if (rtc_if.out_reg_wr === 1'b0) n_rw0++;
      if (rtc_if.out_fin !== 1'b1 && rtc_if.out_ocupado !== 1'b1) ocup_ok = 1'b0;
    end while (rtc_if.out_fin !== 1'b1 && ciclos < limite);
  endtask

  task automatic esperar_grupo(input int primero, input int ultimo);
    for (int i = primero; i <= ultimo; i++) begin
      exp_q.push_back({1'b0, tab_dir[i]});
      exp_q.push_back({1'b1, mux_tab[i]});
    end
    if (EXTRA == 1) begin
      exp_q.push_back(9'h0F0);
      exp_q.push_back(9'h1F0);
    end
  endtask

  task automatic comparar(input string tag);
    chk({tag, "_n_writes"}, obs_n - rd_ptr, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("%s_write%0d", tag, i), {23'd0, obs_mem[(rd_ptr + i) % 128]}, {23'd0, exp_q[i]});
    rd_ptr = obs_n;
    exp_q.delete();
    chk({tag, "_protocol"}, viol, 0);
  endtask

  task automatic chk_reposo(input string tag);
    chk({tag, "_cs_n"}, rtc_if.out_cs_n, 1);
    chk({tag, "_wr_n"}, rtc_if.out_wr_n, 1);
    chk({tag, "_oe"}, rtc_if.out_ad_oe, 0);
    chk({tag, "_ocupado"}, rtc_if.out_ocupado, 0);
    chk({tag, "_fin"}, rtc_if.out_fin, 0);
    chk({tag, "_reg_wr"}, rtc_if.out_reg_wr, 1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int ciclos, n_rw0;
    bit ocup_ok, fin_visto;
    rtc_if.in_iniciar = 1'b0;
    rtc_if.in_sel_grupo = 2'b00;
    for (int i = 0; i < 10; i++) mux_tab[i] = 8'h00;
    mux_tab[0] = 8'h45; mux_tab[1] = 8'h30; mux_tab[2] = 8'h12;

    repeat (3) @(posedge clk);
    #1;
    chk_reposo("reset");
    chk("reset_addr", rtc_if.out_addr_mem_local, 0);
    chk("reset_bus", rtc_if.out_ad_bus, 0);
    chk("reset_rd_n", rtc_if.out_rd_n, 1);
    chk("reset_a_d_n", rtc_if.out_a_d_n, 1);
    chk("reset_state", rtc_if.dbg_estado, 0);
    reset = 1'b0;

    // hora group: three write pairs, out_fin 79 edges after acceptance
    iniciar(2'b00);
    chk("hora_latency", rtc_if.out_ocupado, 0);
    esperar_fin(400, ciclos, ocup_ok, n_rw0);
    chk("hora_cycles", ciclos, 26 * (3 + EXTRA) + 1);
    chk("hora_ocupado", ocup_ok, 1);
    chk("hora_reg_wr_low", n_rw0, 78);
    chk("hora_reg_wr_fin", rtc_if.out_reg_wr, 1);
    @(posedge clk); #1;
    chk("hora_fin_pulse", rtc_if.out_fin, 0);
    esperar_grupo(0, 2);
    comparar("hora");

    // all registers: ten pairs in table order
    for (int i = 0; i < 10; i++) mux_tab[i] = 8'(8'hA0 + 8'(i * 11));
    iniciar(2'b11);
    esperar_fin(1000, ciclos, ocup_ok, n_rw0);
    chk("all_cycles", ciclos, 26 * (10 + EXTRA) + 1);
    chk("all_reg_wr_low", n_rw0, 260);
    @(posedge clk); #1;
    chk("all_reg_wr_after", rtc_if.out_reg_wr, 1);
    esperar_grupo(0, 9);
    comparar("all");

    // second start pulse while busy is dropped
    iniciar(2'b01);
    repeat (30) @(posedge clk);
    #1;
    rtc_if.in_sel_grupo = 2'b10;
    rtc_if.in_iniciar = 1'b1;
    @(posedge clk); #1;
    rtc_if.in_iniciar = 1'b0;
    esperar_fin(400, ciclos, ocup_ok, n_rw0);
    chk("busy_cycles", ciclos, 26 * (4 + EXTRA) + 1 - 31);
    repeat (5) @(posedge clk);
    #1;
    chk("busy_idle", rtc_if.out_ocupado, 0);
    esperar_grupo(3, 6);
    comparar("busy");

    // start held high: one group, then a fresh start on the first idle cycle; sel latched at start
    @(posedge clk); #1;
    rtc_if.in_sel_grupo = 2'b10;
    rtc_if.in_iniciar = 1'b1;
    @(posedge clk); #1;
    rtc_if.in_sel_grupo = 2'b01;
    esperar_fin(400, ciclos, ocup_ok, n_rw0);
    chk("hold1_cycles", ciclos, 26 * (3 + EXTRA) + 1);
    chk("hold1_reg_wr_low", n_rw0, 78);
    @(posedge clk); #1;
    chk("hold_gap_ocupado", rtc_if.out_ocupado, 0);
    rtc_if.in_iniciar = 1'b0;
    esperar_fin(400, ciclos, ocup_ok, n_rw0);
    chk("hold2_cycles", ciclos, 26 * (4 + EXTRA) + 1);
    chk("hold2_ocupado", ocup_ok, 1);
    esperar_grupo(7, 9);
    esperar_grupo(3, 6);
    comparar("hold");

    // reset during the data strobe of byte 2
    mux_tab[0] = 8'h45; mux_tab[1] = 8'h30; mux_tab[2] = 8'h12;
    iniciar(2'b00);
    repeat (45) @(posedge clk);
    #1;
    chk("abort_in_dat_wr", {rtc_if.out_wr_n, rtc_if.out_a_d_n}, 2'b01);
    reset = 1'b1;
    @(posedge clk); #1;
    chk_reposo("abort");
    reset = 1'b0;
    fin_visto = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (rtc_if.out_fin === 1'b1) fin_visto = 1'b1;
    end
    chk("abort_no_fin", fin_visto, 0);
    exp_q.push_back(9'h021); exp_q.push_back(9'h145);
    exp_q.push_back(9'h022); exp_q.push_back(9'h130);
    comparar("abort");

    // timer group after the abort
    mux_tab[7] = 8'h5A; mux_tab[8] = 8'hC3; mux_tab[9] = 8'h01;
    iniciar(2'b10);
    esperar_fin(400, ciclos, ocup_ok, n_rw0);
    chk("timer_cycles", ciclos, 26 * (3 + EXTRA) + 1);
    chk("timer_ocupado", ocup_ok, 1);
    chk("timer_reg_wr_low", n_rw0, 78);
    esperar_grupo(7, 9);
    comparar("timer");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule
